// File: rtl/arith_divider_if.sv
// arith_divider_if: start/operand request and result bundle for arith_divider (master = requester, slave = divider)
interface arith_divider_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/arith_divider.sv
// arith_divider: N-bit unsigned restoring divider, one quotient bit per cycle; ports clk, rst, dif (start/dividend/divisor in, busy/done/quotient/remainder/div_by_zero out)
module arith_divider #(parameter int N = 4) (
  input logic clk,
  input logic rst,
  arith_divider_if.slave dif
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem, work, dvs, nxt_rem;
  logic [N:0] sh, tr;
  logic nb;
  assign sh = {rem, work[N-1]};
  assign nb = sh >= {1'b0, dvs};
  assign tr = sh - {1'b0, dvs};
  assign nxt_rem = nb ? tr[N-1:0] : sh[N-1:0];
  assign dif.busy = state != IDLE;
  assign dif.done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      work <= '0;
      dvs <= '0;
      dif.quotient <= '0;
      dif.remainder <= '0;
      dif.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dif.start) begin
          work <= dif.dividend;
          dvs <= dif.divisor;
          rem <= '0;
          cnt <= CW'(N);
          if (dif.divisor == '0) begin
            state <= DONE;
            dif.quotient <= '1;
            dif.remainder <= dif.dividend;
            dif.div_by_zero <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          rem <= nxt_rem;
          work <= {work[N-2:0], nb};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            dif.quotient <= {work[N-2:0], nb};
            dif.remainder <= nxt_rem;
            dif.div_by_zero <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/arith_divider.md
ARITH_DIVIDER -- requirements
Module: arith_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have input clk, 1 bit, the sole clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have input start, 1 bit, a request to begin a division; honoured only in IDLE.
REQ-005 The block SHALL have input dividend, N bits, an unsigned numerator sampled on the accepting edge.
REQ-006 The block SHALL have input divisor, N bits, an unsigned denominator sampled on the accepting edge.
REQ-007 The block SHALL have output busy, 1 bit, high in the RUN and DONE states.
REQ-008 The block SHALL have output done, 1 bit, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have output quotient, N bits, the unsigned floor(dividend/divisor).
REQ-010 The block SHALL have output remainder, N bits, equal to dividend - quotient*divisor.
REQ-011 The block SHALL have output div_by_zero, 1 bit, high with the results of a zero-divisor request.

Function
REQ-012 The block SHALL implement a three-state machine: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch the operands, clear the partial remainder, load the step counter with N, and enter RUN; if divisor=0 it SHALL enter DONE instead.
REQ-014 In RUN, the block SHALL perform one restoring step per cycle: shift {partial remainder, working dividend} left by 1, form trial = partial - divisor at N+1 bits, and on no borrow keep the difference and shift in quotient bit 1, otherwise restore and shift in 0.
REQ-015 Each RUN cycle SHALL decrement the counter, and the step that brings it to 0 SHALL move the block to DONE.
REQ-016 Latency SHALL be fixed: with start accepted at edge 0, done SHALL be high in the cycle after edge N+1 (after edge 1 for divide-by-zero), then the block SHALL return to IDLE.
REQ-017 done SHALL be high only in DONE, for exactly one cycle per accepted request.
REQ-018 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold until the next DONE or reset; intermediate RUN values SHALL never appear on the outputs.
REQ-019 For a zero divisor, the outputs SHALL be quotient = all ones, remainder = dividend, div_by_zero = 1; for any other divisor, div_by_zero SHALL be 0.
REQ-020 start SHALL be ignored while busy=1, including in the DONE cycle, and operand changes during RUN SHALL NOT affect the result.
REQ-021 A new start SHALL be accepted in the first IDLE cycle after DONE, giving a back-to-back throughput of one result per N+2 cycles.
REQ-022 Arithmetic SHALL be unsigned, and the N+1-bit trial subtraction SHALL prevent overflow for divisor values up to 2^N - 1.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL enter IDLE, clear the counter and working registers, and set busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0.
REQ-024 rst SHALL take priority over start and over any in-progress RUN or DONE state; an aborted division SHALL produce no done pulse.
REQ-025 A start presented in the first cycle after rst deasserts SHALL be accepted normally.

Verification (N=4)
REQ-026 A bench SHALL drive dividend=13, divisor=3, start for 1 cycle -> busy for 5 cycles, done at cycle 5, quotient=4, remainder=1, div_by_zero=0.
REQ-027 A bench SHALL drive 15/1 -> quotient=15, remainder=0; then 5/7 -> quotient=0, remainder=5; both with done at cycle 5.
REQ-028 A bench SHALL drive 9/0 -> done at cycle 1, quotient=15, remainder=9, div_by_zero=1, then back to IDLE.
REQ-029 A bench SHALL drive 14/4, then at cycle 2 a second start with 7/7 and changed operands -> second start ignored, result quotient=3, remainder=2, a single done pulse.
REQ-030 A bench SHALL drive 12/5 and assert rst at cycle 3 -> no done pulse, all outputs 0; then 12/5 -> quotient=2, remainder=2.
REQ-031 A bench SHALL run an exhaustive sweep of all 256 operand pairs with back-to-back starts -> every result matches the reference model and every done spacing is N+2 cycles (2 for a zero divisor).
